// File: rtl/usb_line_monitor.sv
// usb_line_monitor: USB FS bus-condition monitor (bus reset, suspend, resume) on UTMI LineState
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   fs_ce        one-cycle full-speed bit-rate strobe
//   line_state   UTMI LineState (00=SE0, 01=J, 10=K, 11=SE1)
//   rwake_req    remote-wakeup request pulse (USB_RWAKE_EN only)
//   drive_k      tx PHY must drive K (USB_RWAKE_EN only)
//   usb_rst      level, bus reset in progress
//   rst_start    pulse on bus-reset entry
//   rst_end      pulse on bus-reset exit
//   suspend      level, device suspended
//   resume       level, resume signalling in progress
//   resume_done  pulse when resume ends
//
// Optional feature: define USB_RWAKE_EN to add remote wakeup (RWAKE state, rwake_req, drive_k).
module usb_line_monitor #(
    parameter int RST_TICKS   = 30,
    parameter int SUSP_TICKS  = 36000,
    parameter int RES_TICKS   = 4,
    parameter int RWAKE_TICKS = 12000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fs_ce,
    input  logic [1:0] line_state,
`ifdef USB_RWAKE_EN
    input  logic       rwake_req,
    output logic       drive_k,
`endif
    output logic       usb_rst,
    output logic       rst_start,
    output logic       rst_end,
    output logic       suspend,
    output logic       resume,
    output logic       resume_done
);
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [CNT_W-1:0] L_RST  = CNT_W'(RST_TICKS - 1);
    localparam logic [CNT_W-1:0] L_SUSP = CNT_W'(SUSP_TICKS - 1);
    localparam logic [CNT_W-1:0] L_RES  = CNT_W'(RES_TICKS - 1);

    typedef enum logic [2:0] {
        S_NORMAL,
        S_BUS_RST,
        S_SUSPEND,
        S_RESUME
`ifdef USB_RWAKE_EN
        , S_RWAKE
`endif
    } state_t;

    state_t           r_state, w_next;
    logic [1:0]       r_ls;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rst_start, r_rst_end, r_resume_done;
    logic             w_hit_se0, w_hit_j, w_hit_k;

    // Run length of the current line state; a change restarts it, independent of FSM state
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_ls  <= LS_J;
            r_cnt <= '0;
        end else begin
            r_ls  <= line_state;
            r_cnt <= (line_state != r_ls) ? '0 :
                     (fs_ce && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
        end

    assign w_hit_se0 = fs_ce && r_ls == LS_SE0 && r_cnt == L_RST;
    assign w_hit_j   = fs_ce && r_ls == LS_J   && r_cnt == L_SUSP;
    assign w_hit_k   = fs_ce && r_ls == LS_K   && r_cnt == L_RES;

`ifdef USB_RWAKE_EN
    localparam logic [CNT_W-1:0] L_RWK = CNT_W'(RWAKE_TICKS - 1);
    logic [CNT_W-1:0] r_rwk_cnt;

    // Counts fs_ce ticks spent driving K; held at zero outside RWAKE
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_rwk_cnt <= '0;
        else
            r_rwk_cnt <= (r_state != S_RWAKE) ? '0 :
                         (fs_ce && r_rwk_cnt != '1) ? r_rwk_cnt + 1'b1 : r_rwk_cnt;

    assign drive_k = r_state == S_RWAKE;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_NORMAL:  w_next = w_hit_se0 ? S_BUS_RST : w_hit_j ? S_SUSPEND : S_NORMAL;
            S_BUS_RST: w_next = (r_ls != LS_SE0) ? S_NORMAL : S_BUS_RST;
`ifdef USB_RWAKE_EN
            S_SUSPEND: w_next = w_hit_se0 ? S_BUS_RST : w_hit_k ? S_RESUME :
                                rwake_req ? S_RWAKE : S_SUSPEND;
            S_RWAKE:   w_next = (fs_ce && r_rwk_cnt == L_RWK) ? S_RESUME : S_RWAKE;
`else
            S_SUSPEND: w_next = w_hit_se0 ? S_BUS_RST : w_hit_k ? S_RESUME : S_SUSPEND;
`endif
            S_RESUME:  w_next = (r_ls != LS_K) ? S_NORMAL : S_RESUME;
            default:   w_next = S_NORMAL;
        endcase
    end

    // Pulses are registered alongside the state so they coincide with the level change
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state       <= S_NORMAL;
            r_rst_start   <= 1'b0;
            r_rst_end     <= 1'b0;
            r_resume_done <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_rst_start   <= w_next == S_BUS_RST && r_state != S_BUS_RST;
            r_rst_end     <= r_state == S_BUS_RST && w_next == S_NORMAL;
            r_resume_done <= r_state == S_RESUME && w_next == S_NORMAL;
        end

    assign usb_rst     = r_state == S_BUS_RST;
    assign resume      = r_state == S_RESUME;
`ifdef USB_RWAKE_EN
    assign suspend     = r_state == S_SUSPEND || r_state == S_RESUME || r_state == S_RWAKE;
`else
    assign suspend     = r_state == S_SUSPEND || r_state == S_RESUME;
`endif
    assign rst_start   = r_rst_start;
    assign rst_end     = r_rst_end;
    assign resume_done = r_resume_done;
endmodule

// File: tb/tb_usb_line_monitor.sv
// tb_usb_line_monitor: directed self-checking bench for usb_line_monitor
module tb_usb_line_monitor;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs_ce;
    logic [1:0] line_state;
    logic       usb_rst, rst_start, rst_end, suspend, resume, resume_done;
`ifdef USB_RWAKE_EN
    logic       rwake_req;
    logic       drive_k;
`endif
    int checks = 0;
    int failures = 0;
    logic bad;

    usb_line_monitor #(
        .RST_TICKS(30), .SUSP_TICKS(100), .RES_TICKS(4), .RWAKE_TICKS(20), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fs_ce(fs_ce),
        .line_state(line_state),
`ifdef USB_RWAKE_EN
        .rwake_req(rwake_req),
        .drive_k(drive_k),
`endif
        .usb_rst(usb_rst),
        .rst_start(rst_start),
        .rst_end(rst_end),
        .suspend(suspend),
        .resume(resume),
        .resume_done(resume_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        fs_ce = 1'b1;
        line_state = J;
`ifdef USB_RWAKE_EN
        rwake_req = 1'b0;
`endif
        step();
        step();
        check("rst_usb_rst", usb_rst, 0);
        check("rst_suspend", suspend, 0);
        check("rst_resume", resume, 0);
        check("rst_pulses", {rst_start, rst_end, resume_done}, 0);
        rst = 1'b0;

        // SE0 held 40 cycles: reset declared on the 31st edge
        line_state = SE0;
        repeat (30) step();
        check("se0_30_no_rst", usb_rst, 0);
        step();
        check("se0_31_usb_rst", usb_rst, 1);
        check("se0_31_rst_start", rst_start, 1);
        step();
        check("rst_start_single", rst_start, 0);
        repeat (8) step();
        line_state = J;
        step();
        check("j1_still_rst", usb_rst, 1);
        check("j1_no_rst_end", rst_end, 0);
        step();
        check("j2_usb_rst_low", usb_rst, 0);
        check("j2_rst_end", rst_end, 1);
        step();
        check("rst_end_single", rst_end, 0);

        // 29 SE0 ticks is one short of reset; then J runs to suspend
        bad = 1'b0;
        line_state = SE0;
        repeat (29) begin
            step();
            bad |= usb_rst | rst_start | rst_end;
        end
        line_state = J;
        repeat (100) begin
            step();
            bad |= usb_rst | rst_start | rst_end;
        end
        check("se0_29_no_reset", bad, 0);
        check("j100_no_suspend", suspend, 0);
        step();
        check("j101_suspend", suspend, 1);

        // K debounce to resume, then SE0 ends resume
        line_state = K;
        repeat (4) step();
        check("k4_no_resume", resume, 0);
        step();
        check("k5_resume", resume, 1);
        check("k5_suspend", suspend, 1);
        step();
        line_state = SE0;
        step();
        check("se0_1_resume_held", resume, 1);
        check("se0_1_no_done", resume_done, 0);
        step();
        check("se0_2_resume_low", resume, 0);
        check("se0_2_suspend_low", suspend, 0);
        check("se0_2_resume_done", resume_done, 1);
        step();
        check("resume_done_single", resume_done, 0);
        repeat (27) step();
        check("post_resume_se0_30", usb_rst, 0);
        step();
        check("post_resume_se0_31", usb_rst, 1);

        // Re-suspend, then SE0 from suspend enters bus reset
        line_state = J;
        step();
        step();
        check("exit2_rst_end", rst_end, 1);
        repeat (99) step();
        check("resusp", suspend, 1);
        line_state = SE0;
        repeat (30) step();
        check("susp_se0_30_susp", suspend, 1);
        check("susp_se0_30_rst", usb_rst, 0);
        step();
        check("susp_se0_31_susp", suspend, 0);
        check("susp_se0_31_rst", usb_rst, 1);
        check("susp_se0_31_start", rst_start, 1);

        // Async reset on 3rd BUS_RST cycle
        step();
        step();
        rst = 1'b1;
        #1;
        check("async_usb_rst", usb_rst, 0);
        check("async_pulses", {rst_start, rst_end, resume_done}, 0);
        bad = 1'b0;
        repeat (2) begin
            step();
            bad |= rst_end | usb_rst;
        end
        rst = 1'b0;
        repeat (3) begin
            step();
            bad |= rst_end | usb_rst;
        end
        line_state = J;
        repeat (4) begin
            step();
            bad |= rst_end | usb_rst;
        end
        check("async_no_rst_end", bad, 0);

        // No counting without fs_ce; BUS_RST exit still works with fs_ce low
        fs_ce = 1'b0;
        line_state = SE0;
        repeat (40) step();
        check("no_ce_no_rst", usb_rst, 0);
        fs_ce = 1'b1;
        repeat (29) step();
        check("ce29_no_rst", usb_rst, 0);
        step();
        check("ce30_rst", usb_rst, 1);
        fs_ce = 1'b0;
        line_state = J;
        step();
        step();
        check("no_ce_exit", usb_rst, 0);
        check("no_ce_rst_end", rst_end, 1);
        fs_ce = 1'b1;

`ifdef USB_RWAKE_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (99) step();
        check("rw_no_susp", suspend, 0);
        step();
        check("rw_susp", suspend, 1);
        rwake_req = 1'b1;
        step();
        rwake_req = 1'b0;
        check("rw_drive_k", drive_k, 1);
        check("rw_suspend", suspend, 1);
        line_state = K;
        begin
            int n = 1;
            for (int i = 0; i < 40; i++) begin
                step();
                if (!drive_k) break;
                n++;
            end
            check("rw_k_ticks", n, 20);
        end
        check("rw_resume", resume, 1);
        line_state = J;
        step();
        step();
        check("rw_done", resume_done, 1);
        check("rw_susp_low", suspend, 0);
        rwake_req = 1'b1;
        step();
        rwake_req = 1'b0;
        check("rw_normal_ignored", drive_k, 0);
        step();
        check("rw_normal_ignored2", drive_k, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
